result_drain: RTL
=================

RESULT_DRAIN -- requirements
Module: result_drain

Interface
REQ-001 M, 3, number of result rows.
REQ-002 N, 3, number of result columns.
REQ-003 OUTPUT_DATA_WIDTH, 16, width of one result element.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 done_in  input  1  one-cycle pulse: result_in holds a complete matrix.
REQ-007 result_in  input  OUTPUT_DATA_WIDTH*M*N  packed result matrix; element (r,c) at bits ((r*N+c)*OUTPUT_DATA_WIDTH) +: OUTPUT_DATA_WIDTH.
REQ-008 out_valid  output  1  out_data, out_row, out_col and out_last are valid.
REQ-009 out_ready  input  1  downstream accepts the current beat.
REQ-010 out_data  output  OUTPUT_DATA_WIDTH  current element value.
REQ-011 out_row  output  $clog2(M+1)  row index of the current element.
REQ-012 out_col  output  $clog2(N+1)  column index of the current element.
REQ-013 out_last  output  1  current element is (M-1,N-1).
REQ-014 busy  output  1  a captured matrix is being streamed.
REQ-015 overrun  output  1  sticky flag: a done_in pulse was dropped.
REQ-016 overrun_clr  input  1  synchronous clear of overrun.

Function
REQ-017 FSM has two states, IDLE and STREAM; busy = (state == STREAM); out_valid = busy.
REQ-018 IDLE with done_in=1: capture result_in into an internal shadow register, set row=0 and col=0, and enter STREAM on the next edge; out_valid is first high the cycle after done_in (latency 1).
REQ-019 A beat transfers when out_valid and out_ready are both 1.
REQ-020 While out_valid=1 and out_ready=0, out_data, out_row, out_col and out_last hold their values.
REQ-021 Element order is row-major: col increments per transfer; when col=N-1, col wraps to 0 and row increments.
REQ-022 out_data is the shadow element (out_row,out_col); changes on result_in after capture have no effect on out_data.
REQ-023 Transfer with out_last=1 and done_in=0: return to IDLE; out_valid is 0 the next cycle.
REQ-024 Transfer with out_last=1 and done_in=1 in the same cycle: recapture, reset the indices to (0,0), and stay in STREAM, with no idle gap and no overrun.
REQ-025 done_in in STREAM, other than in the REQ-024 case: the pulse is ignored, the stream continues unchanged, and overrun is set to 1.
REQ-026 overrun_clr=1 clears overrun; if it coincides with a new overrun event, the set wins.
REQ-027 M=1 or N=1 is legal; with M=N=1, out_last=1 on the only beat.

Reset
REQ-028 While rst=0: state=IDLE, out_valid=0, busy=0, out_last=0, overrun=0, out_row=0, out_col=0, out_data=0, shadow register=0.
REQ-029 Reset asserted mid-stream aborts the stream immediately (asynchronously); the next done_in restarts at (0,0).

Structure
REQ-030 The shared package holds the default OUTPUT_DATA_WIDTH, the FSM state encodings, and the element-offset macro ((r*N+c)*W); the matrix top and the drain both use them.
REQ-031 One sub-module, index_counter, is instantiated twice (row and col): a wrap-at-MAX counter with increment enable and synchronous load-zero.

Verification
REQ-032 M=N=3, W=16, element (r,c)=3r+c+1, out_ready held 1, done_in pulsed once -> out_valid rises 1 cycle later; 9 consecutive beats with data 1..9 and (row,col) (0,0)..(2,2); out_last only on beat 9; out_valid=0 afterwards.
REQ-033 Same matrix, out_ready alternating 1,0 -> outputs hold during each stall; exactly 9 transfers, in order 1..9, with no duplicates.
REQ-034 done_in pulsed at beat 4 with result_in changed to all 0xFFFF -> overrun=1; the remaining beats still carry 5..9; an overrun_clr pulse then returns overrun to 0.
REQ-035 Second matrix (values 0x10..0x18) with done_in coincident with the beat-9 transfer -> 0x10 is presented the next cycle with no gap; overrun stays 0.
REQ-036 rst driven low during the stall at beat 4 -> out_valid=0, busy=0, overrun=0 immediately; after release, a done_in pulse streams again from value 1 at (0,0).
REQ-037 M=1, N=1, element 0x00AB -> single beat with out_data=0x00AB and out_last=1, then return to IDLE.

Source files
------------

// File: rtl/result_drain_pkg.sv
// Shared definitions for the result drain: default element width, FSM encodings
// and the packed-matrix element offset.
package result_drain_pkg;

  localparam int unsigned DEF_OUTPUT_DATA_WIDTH = 16;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  // Bit offset of element (r,c) in a row-major packed matrix of width w elements.
  function automatic int unsigned elem_offset(input int unsigned r,
                                              input int unsigned c,
                                              input int unsigned n,
                                              input int unsigned w);
    return (r * n + c) * w;
  endfunction

endpackage

// File: rtl/result_drain_index_counter.sv
// Wrap-at-MAX index counter with increment enable and synchronous load-zero.
module index_counter #(
  parameter int unsigned MAX   = 2,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign wrap_o = (cnt_q == MAX_V);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/result_drain.sv
// Captures a completed result matrix and streams it row-major over a valid/ready port.
// state  | meaning
// IDLE   | no matrix held; waiting for done_in
// STREAM | shadow matrix is being presented beat by beat
module result_drain
  import result_drain_pkg::*;
#(
  parameter int unsigned M                 = 3,
  parameter int unsigned N                 = 3,
  parameter int unsigned OUTPUT_DATA_WIDTH = DEF_OUTPUT_DATA_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                done_in,
  input  logic [OUTPUT_DATA_WIDTH*M*N-1:0]    result_in,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [OUTPUT_DATA_WIDTH-1:0]        out_data,
  output logic [$clog2(M+1)-1:0]              out_row,
  output logic [$clog2(N+1)-1:0]              out_col,
  output logic                                out_last,
  output logic                                busy,
  output logic                                overrun,
  input  logic                                overrun_clr
);

  localparam int unsigned RW = $clog2(M + 1);
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned MW = OUTPUT_DATA_WIDTH * M * N;
  localparam int unsigned OW = (MW > 1) ? $clog2(MW) : 1;

  logic [0:0]    state_q, state_d;
  logic [MW-1:0] shadow_q, shadow_d;
  logic          overrun_q, overrun_d;

  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          row_wrap, col_wrap;
  logic          busy_w, xfer, last_w, capture, drop;
  logic [OW-1:0] off;

  assign busy_w  = (state_q == ST_STREAM);
  assign xfer    = busy_w & out_ready;
  assign last_w  = busy_w & row_wrap & col_wrap;
  // A pulse landing on the final transfer refills the shadow back-to-back instead of dropping.
  assign capture = done_in & (~busy_w | (xfer & last_w));
  assign drop    = done_in & busy_w & ~(xfer & last_w);

  index_counter #(.MAX(M - 1), .WIDTH(RW)) u_row (
    .clk_i  (clk),
    .rst_ni (rst),
    .inc_i  (xfer & col_wrap),
    .clr_i  (capture),
    .cnt_o  (row),
    .wrap_o (row_wrap)
  );

  index_counter #(.MAX(N - 1), .WIDTH(CW)) u_col (
    .clk_i  (clk),
    .rst_ni (rst),
    .inc_i  (xfer),
    .clr_i  (capture),
    .cnt_o  (col),
    .wrap_o (col_wrap)
  );

  always_comb begin
    state_d = state_q;
    if (capture)             state_d = ST_STREAM;
    else if (xfer && last_w) state_d = ST_IDLE;
  end

  assign shadow_d  = capture ? result_in : shadow_q;
  assign overrun_d = drop ? 1'b1 : (overrun_clr ? 1'b0 : overrun_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      shadow_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      overrun_q <= overrun_d;
    end
  end

  assign off = OW'(elem_offset(32'(row), 32'(col), N, OUTPUT_DATA_WIDTH));

  assign busy      = busy_w;
  assign out_valid = busy_w;
  assign out_last  = last_w;
  assign out_row   = row;
  assign out_col   = col;
  assign out_data  = busy_w ? shadow_q[off +: OUTPUT_DATA_WIDTH] : '0;
  assign overrun   = overrun_q;

endmodule
